cb_controller: RTL and testbench

- Control block of the matrix-vector co-processor.
- Exposes a 32-bit AXI4 (single-beat, AXI-Lite style) slave CSR bank to the host.
- On a start command, sequences three DMA transfers and one MAC run: load input vector, load matrix, run the MAC array, store the output vector.
- Reports busy, done and error in a status register that software polls.

---
 rtl/cb_pkg.sv | 36 +++
 rtl/cb_controller_if.sv | 44 ++++
 rtl/cb_axi_csr.sv | 127 ++++++++++++
 rtl/cb_controller.sv | 85 ++++++++
 tb/tb_cb_controller.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cb_pkg.sv
// Shared register map, status/control bit positions and FSM encodings for
// the matrix-vector co-processor control block.
package cb_pkg;
    localparam logic [15:0] REG_CTRL   = 16'h0000;
    localparam logic [15:0] REG_STATUS = 16'h0004;
    localparam logic [15:0] REG_VI     = 16'h0010;
    localparam logic [15:0] REG_MI     = 16'h0014;
    localparam logic [15:0] REG_VO     = 16'h0018;
    localparam logic [15:0] REG_ROWS   = 16'h0020;
    localparam logic [15:0] REG_COLS   = 16'h0024;

    localparam int CTRL_START = 0;
    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_ERROR   = 2;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [3:0] {
        SEQ_IDLE, SEQ_VI_REQ, SEQ_VI_WAIT, SEQ_MI_REQ, SEQ_MI_WAIT,
        SEQ_MAC_REQ, SEQ_MAC_WAIT, SEQ_VO_REQ, SEQ_VO_WAIT, SEQ_DONE
    } seq_state_t;

    typedef enum logic [1:0] {AW_IDLE, W_DATA, B_RESP} wr_state_t;
    typedef enum logic       {AR_IDLE, R_DATA}         rd_state_t;

    function automatic logic [31:0] apply_strb(input logic [31:0] old,
                                               input logic [31:0] data,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (strb[i]) r[8*i +: 8] = data[8*i +: 8];
        return r;
    endfunction
endpackage

// File: rtl/cb_controller_if.sv
// Single-beat AXI4 slave bus used by the host to reach the CSR bank.
interface cb_controller_if #(parameter int ID_W = 5);
    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic            awlock;
    logic [3:0]      awcache;
    logic [2:0]      awprot;
    logic            awvalid, awready;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast, wvalid, wready;
    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic            bvalid, bready;
    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic            arlock;
    logic [3:0]      arcache;
    logic [2:0]      arprot;
    logic            arvalid, arready;
    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast, rvalid, rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output wdata, wstrb, wlast, wvalid, bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
        input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
    );
    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  wdata, wstrb, wlast, wvalid, bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
        output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/cb_axi_csr.sv
// AXI slave write/read FSMs and the CSR file. Config registers are frozen
// while the sequencer is busy; CTRL stays writable.
module cb_axi_csr
    import cb_pkg::*;
#(
    parameter int ID_W = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    cb_controller_if.slave s,
    input  logic        busy,
    input  logic        done,
    input  logic        error,
    output logic        start,
    output logic [31:0] vi_base,
    output logic [31:0] mi_base,
    output logic [31:0] vo_base,
    output logic [31:0] rows,
    output logic [31:0] cols
);
    wr_state_t       wr_state, wr_nx;
    rd_state_t       rd_state, rd_nx;
    logic [15:0]     waddr;
    logic [ID_W-1:0] bid_q, rid_q;
    logic [31:0]     ctrl, rdata_q, rsel, status;
    logic            wr_en;
    logic            unused_ok;

    assign unused_ok = ^{s.awaddr[31:16], s.araddr[31:16], s.awlen, s.awsize, s.awburst,
                         s.awlock, s.awcache, s.awprot, s.arlen, s.arsize, s.arburst,
                         s.arlock, s.arcache, s.arprot, s.wlast};

    assign status  = {29'd0, error, done, busy};
    assign start   = ctrl[CTRL_START];
    assign wr_en   = (wr_state == W_DATA) && s.wvalid;
    assign s.bid   = bid_q;
    assign s.rid   = rid_q;
    assign s.rdata = rdata_q;
    assign s.bresp = RESP_OKAY;
    assign s.rresp = RESP_OKAY;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state <= AW_IDLE;
            rd_state <= AR_IDLE;
        end else begin
            wr_state <= wr_nx;
            rd_state <= rd_nx;
        end
    end

    // Ready/valid depend only on state, so no valid-to-ready comb path exists.
    always_comb begin
        wr_nx     = wr_state;
        rd_nx     = rd_state;
        s.awready = 1'b0;
        s.wready  = 1'b0;
        s.bvalid  = 1'b0;
        s.arready = 1'b0;
        s.rvalid  = 1'b0;
        s.rlast   = 1'b0;
        case (wr_state)
            AW_IDLE: begin s.awready = 1'b1; if (s.awvalid) wr_nx = W_DATA;  end
            W_DATA:  begin s.wready  = 1'b1; if (s.wvalid)  wr_nx = B_RESP;  end
            B_RESP:  begin s.bvalid  = 1'b1; if (s.bready)  wr_nx = AW_IDLE; end
            default: wr_nx = AW_IDLE;
        endcase
        case (rd_state)
            AR_IDLE: begin s.arready = 1'b1; if (s.arvalid) rd_nx = R_DATA; end
            R_DATA: begin
                s.rvalid = 1'b1;
                s.rlast  = 1'b1;
                if (s.rready) rd_nx = AR_IDLE;
            end
            default: rd_nx = AR_IDLE;
        endcase
    end

    always_comb begin
        rsel = '0;
        case (s.araddr[15:0])
            REG_CTRL:   rsel = ctrl;
            REG_STATUS: rsel = status;
            REG_VI:     rsel = vi_base;
            REG_MI:     rsel = mi_base;
            REG_VO:     rsel = vo_base;
            REG_ROWS:   rsel = rows;
            REG_COLS:   rsel = cols;
            default:    rsel = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waddr   <= '0;
            bid_q   <= '0;
            rid_q   <= '0;
            rdata_q <= '0;
            ctrl    <= '0;
            vi_base <= '0;
            mi_base <= '0;
            vo_base <= '0;
            rows    <= '0;
            cols    <= '0;
        end else begin
            if (wr_state == AW_IDLE && s.awvalid) begin
                waddr <= s.awaddr[15:0];
                bid_q <= s.awid;
            end
            if (rd_state == AR_IDLE && s.arvalid) begin
                rdata_q <= rsel;
                rid_q   <= s.arid;
            end
            if (wr_en) begin
                case (waddr)
                    REG_CTRL: ctrl    <= apply_strb(ctrl, s.wdata, s.wstrb);
                    REG_VI:   if (!busy) vi_base <= apply_strb(vi_base, s.wdata, s.wstrb);
                    REG_MI:   if (!busy) mi_base <= apply_strb(mi_base, s.wdata, s.wstrb);
                    REG_VO:   if (!busy) vo_base <= apply_strb(vo_base, s.wdata, s.wstrb);
                    REG_ROWS: if (!busy) rows    <= apply_strb(rows, s.wdata, s.wstrb);
                    REG_COLS: if (!busy) cols    <= apply_strb(cols, s.wdata, s.wstrb);
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: rtl/cb_controller.sv
// Control block top: CSR bank plus the load-vector / load-matrix / MAC /
// store-vector sequencer driving the DMA engine and MAC array.
module cb_controller
    import cb_pkg::*;
#(
    parameter int ID_W       = 5,
    parameter int ELEM_BYTES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    cb_controller_if.slave s,
    output logic        dma_start,
    output logic [31:0] dma_addr,
    output logic [31:0] dma_len,
    output logic        dma_dir,
    input  logic        dma_done,
    input  logic        dma_error,
    output logic        mac_start,
    input  logic        mac_done,
    input  logic        mac_error
);
    localparam logic [31:0] EB = 32'(ELEM_BYTES);

    seq_state_t  state, state_nx;
    logic        start, busy, done, error, fail, in_wait;
    logic [31:0] vi_base, mi_base, vo_base, rows, cols;

    cb_axi_csr #(.ID_W(ID_W)) u_csr (
        .clk(clk), .rst_n(rst_n), .s(s),
        .busy(busy), .done(done), .error(error), .start(start),
        .vi_base(vi_base), .mi_base(mi_base), .vo_base(vo_base),
        .rows(rows), .cols(cols)
    );

    assign fail    = dma_error || mac_error;
    assign in_wait = (state == SEQ_VI_WAIT) || (state == SEQ_MI_WAIT) ||
                     (state == SEQ_MAC_WAIT) || (state == SEQ_VO_WAIT);

    always_comb begin
        state_nx  = state;
        dma_start = 1'b0;
        mac_start = 1'b0;
        busy      = 1'b1;
        case (state)
            SEQ_IDLE:     begin busy = 1'b0; if (start) state_nx = SEQ_VI_REQ; end
            SEQ_VI_REQ:   begin dma_start = 1'b1; state_nx = SEQ_VI_WAIT; end
            SEQ_VI_WAIT:  if (fail) state_nx = SEQ_DONE; else if (dma_done) state_nx = SEQ_MI_REQ;
            SEQ_MI_REQ:   begin dma_start = 1'b1; state_nx = SEQ_MI_WAIT; end
            SEQ_MI_WAIT:  if (fail) state_nx = SEQ_DONE; else if (dma_done) state_nx = SEQ_MAC_REQ;
            SEQ_MAC_REQ:  begin mac_start = 1'b1; state_nx = SEQ_MAC_WAIT; end
            SEQ_MAC_WAIT: if (fail) state_nx = SEQ_DONE; else if (mac_done) state_nx = SEQ_VO_REQ;
            SEQ_VO_REQ:   begin dma_start = 1'b1; state_nx = SEQ_VO_WAIT; end
            SEQ_VO_WAIT:  if (fail) state_nx = SEQ_DONE; else if (dma_done) state_nx = SEQ_DONE;
            // Leave only once start is low so a start bit left set never retriggers.
            SEQ_DONE:     begin busy = 1'b0; if (!start) state_nx = SEQ_IDLE; end
            default:      state_nx = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SEQ_IDLE;
            done     <= 1'b0;
            error    <= 1'b0;
            dma_addr <= '0;
            dma_len  <= '0;
            dma_dir  <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == SEQ_IDLE && state_nx == SEQ_VI_REQ) begin
                done  <= 1'b0;
                error <= 1'b0;
            end
            if (state != SEQ_DONE && state_nx == SEQ_DONE) done <= 1'b1;
            if (in_wait && fail) error <= 1'b1;
            // Descriptor is loaded on entry to a REQ state and held until the next one.
            case (state_nx)
                SEQ_VI_REQ: begin dma_addr <= vi_base; dma_len <= cols * EB;        dma_dir <= 1'b0; end
                SEQ_MI_REQ: begin dma_addr <= mi_base; dma_len <= rows * cols * EB; dma_dir <= 1'b0; end
                SEQ_VO_REQ: begin dma_addr <= vo_base; dma_len <= rows * EB;        dma_dir <= 1'b1; end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cb_controller.sv
// Randomized bench for cb_controller: CSR traffic and full sequences checked
// against a register-map / request-list model.
module tb_cb_controller;
    localparam logic [31:0] A_CTRL = 32'h00, A_STATUS = 32'h04, A_VI = 32'h10, A_MI = 32'h14;
    localparam logic [31:0] A_VO = 32'h18, A_ROWS = 32'h20, A_COLS = 32'h24;

    typedef struct {
        bit          mac;
        bit          dir;
        logic [31:0] addr;
        logic [31:0] len;
    } req_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        dma_start, dma_dir, mac_start;
    logic [31:0] dma_addr, dma_len;
    logic        dma_done = 1'b0, dma_error = 1'b0, mac_done = 1'b0, mac_error = 1'b0;

    int n_chk = 0, n_pass = 0;
    req_t obs_q[$];
    req_t exp_q[$];
    int dma_cnt = 0, mac_cnt = 0, dma_seen = 0, err_at = -1;
    logic [31:0] m_reg[int];
    bit m_busy, m_done, m_err;

    always #5 clk = ~clk;

    cb_controller_if #(.ID_W(5)) axi ();

    cb_controller #(.ID_W(5), .ELEM_BYTES(4)) dut (
        .clk(clk), .rst_n(rst_n), .s(axi),
        .dma_start(dma_start), .dma_addr(dma_addr), .dma_len(dma_len), .dma_dir(dma_dir),
        .dma_done(dma_done), .dma_error(dma_error),
        .mac_start(mac_start), .mac_done(mac_done), .mac_error(mac_error)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // DMA/MAC responder: logs requests, answers DMA after 10 cycles, MAC after 5.
    always @(negedge clk) begin
        dma_done = 1'b0;
        dma_error = 1'b0;
        mac_done = 1'b0;
        if (dma_cnt > 0) begin
            dma_cnt--;
            if (dma_cnt == 0) begin
                if (dma_seen == err_at) dma_error = 1'b1;
                else dma_done = 1'b1;
            end
        end
        if (mac_cnt > 0) begin
            mac_cnt--;
            if (mac_cnt == 0) mac_done = 1'b1;
        end
        if (rst_n && dma_start) begin
            obs_q.push_back('{mac: 1'b0, dir: dma_dir, addr: dma_addr, len: dma_len});
            dma_cnt = 10;
            dma_seen++;
        end
        if (rst_n && mac_start) begin
            obs_q.push_back('{mac: 1'b1, dir: 1'b0, addr: 32'd0, len: 32'd0});
            mac_cnt = 5;
        end
    end

    function automatic void m_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int k;
        logic [31:0] t;
        k = int'(addr[15:0]);
        if (k == 0 || (!m_busy && (k == 'h10 || k == 'h14 || k == 'h18 || k == 'h20 || k == 'h24))) begin
            t = m_reg.exists(k) ? m_reg[k] : 32'd0;
            for (int b = 0; b < 4; b++) if (strb[b]) t[8*b +: 8] = data[8*b +: 8];
            m_reg[k] = t;
        end
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] addr);
        int k;
        k = int'(addr[15:0]);
        if (k == 4) return {29'd0, m_err, m_done, m_busy};
        if (m_reg.exists(k)) return m_reg[k];
        return 32'd0;
    endfunction

    function automatic void build_exp(input bit inj);
        logic [31:0] r, c;
        r = m_read(A_ROWS);
        c = m_read(A_COLS);
        exp_q.delete();
        exp_q.push_back('{mac: 1'b0, dir: 1'b0, addr: m_read(A_VI), len: 32'(64'(c) * 4)});
        exp_q.push_back('{mac: 1'b0, dir: 1'b0, addr: m_read(A_MI), len: 32'(64'(r) * 64'(c) * 4)});
        if (!inj) begin
            exp_q.push_back('{mac: 1'b1, dir: 1'b0, addr: 32'd0, len: 32'd0});
            exp_q.push_back('{mac: 1'b0, dir: 1'b1, addr: m_read(A_VO), len: 32'(64'(r) * 4)});
        end
    endfunction

    task automatic axi_wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic [4:0] id;
        int n;
        id = 5'($urandom);
        @(negedge clk);
        axi.awaddr = addr; axi.awid = id; axi.awvalid = 1'b1;
        n = 0;
        while (!axi.awready && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("aw_timeout", axi.awready, 1);
        @(negedge clk);
        axi.awvalid = 1'b0; axi.wdata = data; axi.wstrb = strb; axi.wvalid = 1'b1;
        n = 0;
        while (!axi.wready && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("w_timeout", axi.wready, 1);
        @(negedge clk);
        axi.wvalid = 1'b0;
        n = 0;
        while (!axi.bvalid && n < 20) begin @(negedge clk); n++; end
        chk("bvalid", axi.bvalid, 1);
        chk("bid", axi.bid, id);
        chk("bresp", axi.bresp, 0);
        axi.bready = 1'b1;
        @(negedge clk);
        axi.bready = 1'b0;
        m_write(addr, data, strb);
    endtask

    task automatic axi_rd(input logic [31:0] addr, output logic [31:0] data);
        logic [4:0] id;
        int n;
        id = 5'($urandom);
        @(negedge clk);
        axi.araddr = addr; axi.arid = id; axi.arvalid = 1'b1;
        n = 0;
        while (!axi.arready && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("ar_timeout", axi.arready, 1);
        @(negedge clk);
        axi.arvalid = 1'b0;
        n = 0;
        while (!axi.rvalid && n < 20) begin @(negedge clk); n++; end
        chk("rvalid", axi.rvalid, 1);
        chk("rid", axi.rid, id);
        chk("rlast", axi.rlast, 1);
        chk("rresp", axi.rresp, 0);
        data = axi.rdata;
        axi.rready = 1'b1;
        @(negedge clk);
        axi.rready = 1'b0;
    endtask

    task automatic rd_chk(input logic [31:0] addr, input string tag);
        logic [31:0] v;
        axi_rd(addr, v);
        chk(tag, v, m_read(addr));
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_dma_start"}, dma_start, 0);
        chk({tag, "_dma_addr"}, dma_addr, 0);
        chk({tag, "_dma_len"}, dma_len, 0);
        chk({tag, "_dma_dir"}, dma_dir, 0);
        chk({tag, "_mac_start"}, mac_start, 0);
        chk({tag, "_awready"}, axi.awready, 1);
        chk({tag, "_arready"}, axi.arready, 1);
        chk({tag, "_wready"}, axi.wready, 0);
        chk({tag, "_bvalid"}, axi.bvalid, 0);
        chk({tag, "_bid"}, axi.bid, 0);
        chk({tag, "_rvalid"}, axi.rvalid, 0);
        chk({tag, "_rlast"}, axi.rlast, 0);
        chk({tag, "_rid"}, axi.rid, 0);
        chk({tag, "_rdata"}, axi.rdata, 0);
    endtask

    task automatic config_regs(input logic [31:0] vi, mi, vo, r, c, input bit rnd_strb);
        logic [31:0] val[5];
        logic [31:0] adr[5];
        logic [3:0] st;
        val = '{vi, mi, vo, r, c};
        adr = '{A_VI, A_MI, A_VO, A_ROWS, A_COLS};
        for (int i = 0; i < 5; i++) begin
            st = rnd_strb ? 4'($urandom_range(1, 15)) : 4'hf;
            axi_wr(adr[i], val[i], st);
        end
        for (int i = 0; i < 5; i++) rd_chk(adr[i], "readback");
    endtask

    task automatic run_seq(input bit inj, input bit clr_mid, input bit poke);
        logic [31:0] v;
        int base, n;
        build_exp(inj);
        base = obs_q.size();
        err_at = inj ? dma_seen + 2 : -1;
        axi_wr(A_CTRL, 32'h1, 4'hf);
        m_busy = 1'b1; m_done = 1'b0; m_err = 1'b0;
        rd_chk(A_STATUS, "status_mid");
        if (poke) axi_wr(A_ROWS, 32'h7, 4'hf);
        if (clr_mid) axi_wr(A_CTRL, 32'h0, 4'hf);
        n = 0;
        do begin axi_rd(A_STATUS, v); n++; end while (v[0] && n < 100);
        chk("busy_clear", v[0], 0);
        m_busy = 1'b0; m_done = 1'b1; m_err = inj;
        chk("status_end", v, m_read(A_STATUS));
        chk("req_count", obs_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < obs_q.size()) begin
                chk("req_mac", obs_q[base+i].mac, exp_q[i].mac);
                chk("req_dir", obs_q[base+i].dir, exp_q[i].dir);
                chk("req_addr", obs_q[base+i].addr, exp_q[i].addr);
                chk("req_len", obs_q[base+i].len, exp_q[i].len);
            end
        end
        if (poke) rd_chk(A_ROWS, "rows_locked");
        if (!clr_mid) begin
            axi_wr(A_CTRL, 32'h0, 4'hf);
            rd_chk(A_STATUS, "status_after_clr");
        end
        repeat (15) @(negedge clk);
        chk("no_retrigger", obs_q.size() - base, exp_q.size());
    endtask

    function automatic logic [31:0] pick_dim();
        case ($urandom_range(0, 3))
            0: return 32'd0;
            1: return 32'($urandom_range(1, 64));
            2: return 32'h0001_0000 | 32'($urandom_range(0, 3));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        axi.awid = '0; axi.awaddr = '0; axi.awlen = 8'd0; axi.awsize = 3'd2; axi.awburst = 2'd1;
        axi.awlock = 1'b0; axi.awcache = 4'd0; axi.awprot = 3'd0; axi.awvalid = 1'b0;
        axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b1; axi.wvalid = 1'b0; axi.bready = 1'b0;
        axi.arid = '0; axi.araddr = '0; axi.arlen = 8'd0; axi.arsize = 3'd2; axi.arburst = 2'd1;
        axi.arlock = 1'b0; axi.arcache = 4'd0; axi.arprot = 3'd0; axi.arvalid = 1'b0;
        axi.rready = 1'b0;
        m_reg.delete(); m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        rd_chk(A_STATUS, "status_reset");

        config_regs(32'h1000_0000, 32'h2000_0000, 32'h3000_0000, 32'd32, 32'd32, 1'b0);
        run_seq(1'b0, 1'b0, 1'b0);
        run_seq(1'b0, 1'b0, 1'b0);
        run_seq(1'b1, 1'b0, 1'b0);
        run_seq(1'b0, 1'b0, 1'b1);
        run_seq(1'b0, 1'b1, 1'b0);

        axi_wr(32'h30, $urandom, 4'hf);
        rd_chk(32'h30, "unmapped");
        rd_chk(32'hABCD_0010, "alias_vi");
        axi_wr(A_STATUS, 32'hFFFF_FFFF, 4'hf);
        rd_chk(A_STATUS, "status_ro");

        for (int it = 0; it < 5; it++) begin
            config_regs($urandom, $urandom, $urandom, pick_dim(), pick_dim(), 1'b1);
            run_seq($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
        end

        config_regs(32'h1000_0000, 32'h2000_0000, 32'h3000_0000, 32'd32, 32'd32, 1'b0);
        axi_wr(A_CTRL, 32'h1, 4'hf);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("midrun_reset");
        m_reg.delete(); m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rd_chk(A_STATUS, "status_post_reset");
        rd_chk(A_VI, "vi_post_reset");
        rd_chk(A_CTRL, "ctrl_post_reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
